// File: rtl/truth_table_sweep.sv
// rtl/truth_table_sweep.sv - exhaustive truth-table equivalence sweep; optional HALT_ON_FAIL_EN stops at first mismatch
module truth_table_sweep #(
  parameter int N = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              use_ext,
  input  logic [2**N-1:0]   table_a,
  input  logic [2**N-1:0]   table_b,
  input  logic              ext_a,
  input  logic              ext_b,
  output logic [N-1:0]      vec,
  output logic              busy,
  output logic              done,
  output logic [N:0]        mismatch_count,
  output logic [N-1:0]      first_fail,
  output logic              fail_seen,
  output logic              equal
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N-1:0] LAST_VEC = {N{1'b1}};

  state_t         state;
  state_t         state_nxt;
  logic           mode;
  logic           mode_nxt;
  logic [N-1:0]   vec_nxt;
  logic [N:0]     count_nxt;
  logic [N-1:0]   first_fail_nxt;
  logic           fail_seen_nxt;
  logic           a_bit;
  logic           b_bit;
  logic           diff;

  // Select the pair under comparison; tables are read live so edits during RUN apply at the next vector
  always_comb begin
    a_bit = mode ? ext_a : table_a[vec];
    b_bit = mode ? ext_b : table_b[vec];
    diff  = a_bit ^ b_bit;
  end

  // Next-state and datapath update: a start clears results, each RUN cycle scores one vector
  always_comb begin
    state_nxt      = state;
    mode_nxt       = mode;
    vec_nxt        = vec;
    count_nxt      = mismatch_count;
    first_fail_nxt = first_fail;
    fail_seen_nxt  = fail_seen;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt      = RUN;
          mode_nxt       = use_ext;
          vec_nxt        = '0;
          count_nxt      = '0;
          first_fail_nxt = '0;
          fail_seen_nxt  = 1'b0;
        end
      end
      RUN: begin
        if (diff) begin
          count_nxt = mismatch_count + (N+1)'(1);
          if (!fail_seen) begin
            first_fail_nxt = vec;
            fail_seen_nxt  = 1'b1;
          end
        end
`ifdef HALT_ON_FAIL_EN
        // Stop on the failing vector so vec and first_fail both point at it
        if (diff || vec == LAST_VEC) begin
          state_nxt = DONE;
        end else begin
          vec_nxt = vec + N'(1);
        end
`else
        // The final vector is held rather than wrapped so it stays visible in DONE
        if (vec == LAST_VEC) begin
          state_nxt = DONE;
        end else begin
          vec_nxt = vec + N'(1);
        end
`endif
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and result registers; reset wins over any start in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      mode           <= 1'b0;
      vec            <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
      fail_seen      <= 1'b0;
    end else begin
      state          <= state_nxt;
      mode           <= mode_nxt;
      vec            <= vec_nxt;
      mismatch_count <= count_nxt;
      first_fail     <= first_fail_nxt;
      fail_seen      <= fail_seen_nxt;
    end
  end

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign equal = done && (mismatch_count == '0);

endmodule

// File: tb/tb_truth_table_sweep.sv
// tb/tb_truth_table_sweep.sv - directed-vector bench for truth_table_sweep
module tb_truth_table_sweep;

  localparam int N = 4;
`ifdef HALT_ON_FAIL_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            start;
  logic            use_ext;
  logic [15:0]     table_a;
  logic [15:0]     table_b;
  logic            ext_a;
  logic            ext_b;
  logic [N-1:0]    vec;
  logic            busy;
  logic            done;
  logic [N:0]      mismatch_count;
  logic [N-1:0]    first_fail;
  logic            fail_seen;
  logic            equal;
  logic            inject;

  int total = 0;
  int bad   = 0;
  int cyc;
  int v0;

  truth_table_sweep #(.N(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .use_ext        (use_ext),
    .table_a        (table_a),
    .table_b        (table_b),
    .ext_a          (ext_a),
    .ext_b          (ext_b),
    .vec            (vec),
    .busy           (busy),
    .done           (done),
    .mismatch_count (mismatch_count),
    .first_fail     (first_fail),
    .fail_seen      (fail_seen),
    .equal          (equal)
  );

  always #5 clk = ~clk;

  // External implementations: x&~w | x&w&~z, B optionally flipped at vector 13
  assign ext_a = (vec[3] & ~vec[1]) | (vec[3] & vec[1] & ~vec[0]);
  assign ext_b = ext_a ^ (inject && vec == 4'd13);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start, then count RUN cycles at falling edges; optionally re-pulse start at vector poke
  task automatic do_sweep(input logic ext, input int poke, output int n_cyc, output int first_vec);
    start   = 1'b1;
    use_ext = ext;
    @(negedge clk);
    start     = 1'b0;
    first_vec = int'(vec);
    n_cyc     = 0;
    while (busy && n_cyc < 100) begin
      n_cyc++;
      start = (poke >= 0) && (int'(vec) == poke);
      @(negedge clk);
    end
    start = 1'b0;
    check_val("sweep_terminates", 32'(done), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_vec"},   32'(vec), 0);
    check_val({tag, "_busy"},  32'(busy), 0);
    check_val({tag, "_done"},  32'(done), 0);
    check_val({tag, "_count"}, 32'(mismatch_count), 0);
    check_val({tag, "_ff"},    32'(first_fail), 0);
    check_val({tag, "_fs"},    32'(fail_seen), 0);
    check_val({tag, "_eq"},    32'(equal), 0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    use_ext = 1'b0;
    inject  = 1'b0;
    table_a = 16'hFF00;
    table_b = 16'hFF00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // Identical tables
    do_sweep(1'b0, -1, cyc, v0);
    check_val("eq_first_vec", 32'(v0), 0);
    check_val("eq_cycles", 32'(cyc), 16);
    check_val("eq_done", 32'(done), 1);
    check_val("eq_equal", 32'(equal), 1);
    check_val("eq_count", 32'(mismatch_count), 0);
    check_val("eq_fs", 32'(fail_seen), 0);
    check_val("eq_vec_hold", 32'(vec), 15);
    repeat (3) @(negedge clk);
    check_val("eq_done_held", 32'(done), 1);
    check_val("eq_vec_held", 32'(vec), 15);

    // Single mismatch at vector 2
    table_b = 16'hFF04;
    do_sweep(1'b0, -1, cyc, v0);
    check_val("one_cycles", 32'(cyc), HALT ? 3 : 16);
    check_val("one_count", 32'(mismatch_count), 1);
    check_val("one_ff", 32'(first_fail), 2);
    check_val("one_fs", 32'(fail_seen), 1);
    check_val("one_equal", 32'(equal), 0);

    // Complemented table: every vector mismatches
    table_b = ~table_a;
    do_sweep(1'b0, -1, cyc, v0);
    check_val("inv_cycles", 32'(cyc), HALT ? 1 : 16);
    check_val("inv_count", 32'(mismatch_count), HALT ? 1 : 16);
    check_val("inv_ff", 32'(first_fail), 0);
    check_val("inv_vec", 32'(vec), HALT ? 0 : 15);

    // External mode, B inverted at vector 13; tables are mismatched to show they are ignored
    inject = 1'b1;
    do_sweep(1'b1, -1, cyc, v0);
    check_val("ext_cycles", 32'(cyc), HALT ? 14 : 16);
    check_val("ext_count", 32'(mismatch_count), 1);
    check_val("ext_ff", 32'(first_fail), 13);
    check_val("ext_fs", 32'(fail_seen), 1);
    inject = 1'b0;

    // Reset mid-sweep at vector 7, with reset overriding a simultaneous start
    table_b = table_a;
    use_ext = 1'b0;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc   = 0;
    while (vec != 4'd7 && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check_val("rst_reached7", 32'(vec), 7);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("midrst");
    start = 1'b1;
    @(negedge clk);
    check_val("rst_prio_busy", 32'(busy), 0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    do_sweep(1'b0, -1, cyc, v0);
    check_val("rst_fresh_vec0", 32'(v0), 0);
    check_val("rst_fresh_cycles", 32'(cyc), 16);
    check_val("rst_fresh_equal", 32'(equal), 1);

    // Start pulsed at vector 5 while busy is ignored
    table_b = 16'hFF04;
    do_sweep(1'b0, 5, cyc, v0);
    check_val("busy_start_cycles", 32'(cyc), HALT ? 3 : 16);
    check_val("busy_start_count", 32'(mismatch_count), 1);

    // Restart from DONE clears previous results
    table_b = table_a;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("restart_busy", 32'(busy), 1);
    check_val("restart_done", 32'(done), 0);
    check_val("restart_count", 32'(mismatch_count), 0);
    check_val("restart_fs", 32'(fail_seen), 0);
    check_val("restart_vec", 32'(vec), 0);
    cyc = 0;
    while (!done && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
    check_val("restart_equal", 32'(equal), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
